// File: rtl/rti_pkg.sv
// Shared types for the real-time input capture path.
// An entry is the 64-bit timestamp followed by the 64-bit event word.
package rti_pkg;

   localparam int RTI_ENTRY_W = 128;

   typedef struct packed {
      logic [63:0] timestamp;
      logic [63:0] data;
   } rti_entry_t;

endpackage

// File: rtl/rti_if.sv
// Capture-side bus of the RTI core: event input, CPU read side, status and error reporting.
// The bus driver uses master; the core uses slave.
interface rti_if #(
   parameter int DEPTH = 8192
);
   import rti_pkg::*;

   localparam int CW = $clog2(DEPTH) + 1;

   logic             flush;
   logic             auto_start;
   logic             event_valid;
   logic [63:0]      event_data;
   logic [63:0]      counter;
   logic             read;
   rti_entry_t       rti_out;
   logic [CW-1:0]    count;
   logic             full;
   logic             empty;
   logic             overflow_error;
   rti_entry_t       overflow_error_data;
   logic             underflow_error;

   modport master (
      output flush, auto_start, event_valid, event_data, counter, read,
      input  rti_out, count, full, empty, overflow_error, overflow_error_data, underflow_error
   );

   modport slave (
      input  flush, auto_start, event_valid, event_data, counter, read,
      output rti_out, count, full, empty, overflow_error, overflow_error_data, underflow_error
   );

endinterface

// File: rtl/rti_fifo.sv
// First-word-fall-through FIFO with occupancy, threshold-based full, and flush.
// Head is held in an output register fed by a registered RAM read of the next slot.
module rti_fifo
   import rti_pkg::*;
#(
   parameter int DEPTH       = 8192,
   parameter int FULL_THRESH = 8100,
   localparam int AW         = $clog2(DEPTH),
   localparam int CW         = AW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   input  logic          push,
   input  rti_entry_t    din,
   input  logic          pop,
   output rti_entry_t    dout,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   rti_entry_t    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] rd_nxt;
   logic          wr_en;
   logic          rd_en;

   // full is judged on the pre-pop occupancy, so a push at the threshold drops even with a read
   assign full   = (count >= CW'(FULL_THRESH));
   assign empty  = (count == '0);
   assign wr_en  = push && !full && !flush;
   assign rd_en  = pop && !empty && !flush;
   assign rd_nxt = rd_ptr + AW'(1);

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dout <= '0;
      end else if (!flush) begin
         if (rd_en) begin
            if (count != CW'(1))
               dout <= mem[rd_nxt];
            else if (wr_en)
               dout <= din;
         end else if (wr_en && empty) begin
            dout <= din;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (rd_en) rd_ptr <= rd_nxt;
         case ({wr_en, rd_en})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/rti_core.sv
// Timestamps qualified events into a capture register, pushes them into the FIFO one cycle later,
// and reports dropped captures (overflow) and reads of an empty FIFO (underflow) as one-cycle pulses.
module rti_core
   import rti_pkg::*;
#(
   parameter int DEPTH       = 8192,
   parameter int FULL_THRESH = 8100,
   parameter bit CHANGE_ONLY = 1'b0
) (
   input logic clk,
   input logic reset,
   rti_if.slave bus
);

   rti_entry_t  cap_entry;
   logic        cap_valid;
   logic [63:0] last_data;
   logic        last_valid;
   logic        is_new;
   logic        accept;

   // last_valid=0 forces the first event after reset or flush through the change filter
   assign is_new = !CHANGE_ONLY || !last_valid || (bus.event_data != last_data);
   assign accept = bus.event_valid && bus.auto_start && is_new && !bus.flush;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cap_valid  <= 1'b0;
         cap_entry  <= '0;
         last_data  <= '0;
         last_valid <= 1'b0;
      end else begin
         cap_valid <= accept;
         if (accept) cap_entry <= '{timestamp: bus.counter, data: bus.event_data};
         if (bus.flush) begin
            last_valid <= 1'b0;
         end else if (accept && CHANGE_ONLY) begin
            last_valid <= 1'b1;
            last_data  <= bus.event_data;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.overflow_error      <= 1'b0;
         bus.overflow_error_data <= '0;
         bus.underflow_error     <= 1'b0;
      end else begin
         bus.overflow_error  <= cap_valid && bus.full && !bus.flush;
         bus.underflow_error <= bus.read && bus.empty;
         if (cap_valid && bus.full && !bus.flush) bus.overflow_error_data <= cap_entry;
      end
   end

   rti_fifo #(
      .DEPTH       (DEPTH),
      .FULL_THRESH (FULL_THRESH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (bus.flush),
      .push  (cap_valid),
      .din   (cap_entry),
      .pop   (bus.read),
      .dout  (bus.rti_out),
      .count (bus.count),
      .full  (bus.full),
      .empty (bus.empty)
   );

endmodule

// File: tb/tb_rti_core.sv
// Bench for rti_core: two instances (change filter off/on) share stimulus and are checked
// each cycle against a queue-based reference model plus targeted scenario checks.
module tb_rti_core;
   import rti_pkg::*;

   localparam int DEPTH = 16;
   localparam int FT    = 12;
   localparam int CW    = $clog2(DEPTH) + 1;
   localparam int VW    = 128 + CW + 1 + 1 + 1 + 128 + 1;

   logic        clk;
   logic        reset;
   logic        fl, as, ev, rd;
   logic [63:0] ed, counter;
   int          tests = 0;
   int          fails = 0;

   rti_if #(.DEPTH(DEPTH)) bus0 ();
   rti_if #(.DEPTH(DEPTH)) bus1 ();

   assign bus0.flush = fl;  assign bus0.auto_start = as; assign bus0.event_valid = ev;
   assign bus0.event_data = ed; assign bus0.counter = counter; assign bus0.read = rd;
   assign bus1.flush = fl;  assign bus1.auto_start = as; assign bus1.event_valid = ev;
   assign bus1.event_data = ed; assign bus1.counter = counter; assign bus1.read = rd;

   rti_core #(.DEPTH(DEPTH), .FULL_THRESH(FT), .CHANGE_ONLY(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
   rti_core #(.DEPTH(DEPTH), .FULL_THRESH(FT), .CHANGE_ONLY(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model: one queue of stored entries per instance plus a pending capture
   logic [127:0] mq [2][$];
   logic         m_cv [2];
   logic [127:0] m_ce [2];
   logic         m_lv [2];
   logic [63:0]  m_ld [2];
   logic         m_ovf [2];
   logic         m_unf [2];
   logic [127:0] m_ovd [2];
   logic [127:0] m_head [2];

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         mq[i].delete();
         m_cv[i] = 0; m_ce[i] = '0; m_lv[i] = 0; m_ld[i] = '0;
         m_ovf[i] = 0; m_unf[i] = 0; m_ovd[i] = '0; m_head[i] = '0;
      end
   endtask

   task automatic model_update();
      for (int i = 0; i < 2; i++) begin
         int  n     = mq[i].size();
         bit  fullb = (n >= FT);
         bit  emptb = (n == 0);
         bit  acc;
         m_unf[i] = rd && emptb;
         m_ovf[i] = m_cv[i] && fullb && !fl;
         if (m_ovf[i]) m_ovd[i] = m_ce[i];
         if (fl) begin
            mq[i].delete(); m_cv[i] = 0; m_lv[i] = 0;
         end else begin
            if (rd && !emptb) void'(mq[i].pop_front());
            if (m_cv[i] && !fullb) mq[i].push_back(m_ce[i]);
            acc = ev && as && (i == 0 || !m_lv[i] || ed != m_ld[i]);
            m_cv[i] = acc;
            if (acc) m_ce[i] = {counter, ed};
            if (acc && i == 1) begin m_lv[i] = 1; m_ld[i] = ed; end
         end
         if (mq[i].size() > 0) m_head[i] = mq[i][0];
      end
   endtask

   function automatic logic [VW-1:0] exp_vec(int i);
      int n = mq[i].size();
      return {m_head[i], CW'(n), (n >= FT), (n == 0), m_ovf[i], m_ovd[i], m_unf[i]};
   endfunction

   function automatic logic [VW-1:0] dut_vec(int i);
      if (i == 0)
         return {bus0.rti_out, bus0.count, bus0.full, bus0.empty, bus0.overflow_error,
                 bus0.overflow_error_data, bus0.underflow_error};
      return {bus1.rti_out, bus1.count, bus1.full, bus1.empty, bus1.overflow_error,
              bus1.overflow_error_data, bus1.underflow_error};
   endfunction

   task automatic cycle();
      @(posedge clk);
      if (reset) model_update();
      #1;
      counter = counter + 64'd1;
   endtask

   task automatic test_reset();
      reset = 0; fl = 0; as = 0; ev = 0; ed = '0; rd = 0; counter = '0;
      model_reset();
      #12;
      tests++; if (bus0.rti_out !== 128'd0) begin fails++; $display("FAIL reset_rti_out got=%h exp=0", bus0.rti_out); end
      tests++; if (bus0.count !== CW'(0)) begin fails++; $display("FAIL reset_count got=%0d exp=0", bus0.count); end
      tests++; if (bus0.empty !== 1'b1 || bus0.full !== 1'b0) begin fails++; $display("FAIL reset_flags got empty=%b full=%b exp 1/0", bus0.empty, bus0.full); end
      tests++; if (bus0.overflow_error !== 1'b0 || bus0.underflow_error !== 1'b0 || bus0.overflow_error_data !== 128'd0) begin
         fails++; $display("FAIL reset_errors got ovf=%b unf=%b data=%h exp 0", bus0.overflow_error, bus0.underflow_error, bus0.overflow_error_data); end
      tests++; if (dut_vec(1) !== exp_vec(1)) begin fails++; $display("FAIL reset_vec1 got=%h exp=%h", dut_vec(1), exp_vec(1)); end
      @(negedge clk);
      reset = 1;
   endtask

   task automatic test_basic();
      as = 1; counter = 64'h100; ev = 1; ed = 64'hA5;
      cycle();
      ev = 0;
      tests++; if (bus0.empty !== 1'b1) begin fails++; $display("FAIL basic_empty_n1 got=%b exp=1", bus0.empty); end
      cycle();
      tests++; if (bus0.empty !== 1'b0) begin fails++; $display("FAIL basic_empty_n2 got=%b exp=0", bus0.empty); end
      tests++; if (bus0.rti_out !== {64'h100, 64'hA5}) begin fails++; $display("FAIL basic_rti_out got=%h exp=%h", bus0.rti_out, {64'h100, 64'hA5}); end
      tests++; if (bus0.count !== CW'(1)) begin fails++; $display("FAIL basic_count got=%0d exp=1", bus0.count); end
      rd = 1;
      cycle();
      rd = 0;
      for (int k = 0; k < 2; k++) begin
         tests++; if (dut_vec(k) !== exp_vec(k)) begin fails++; $display("FAIL basic_vec[%0d] got=%h exp=%h", k, dut_vec(k), exp_vec(k)); end
      end
   endtask

   task automatic test_change_only();
      logic [63:0]  seq [5];
      logic [127:0] want [3];
      logic [63:0]  c0;
      seq[0] = 5; seq[1] = 5; seq[2] = 7; seq[3] = 7; seq[4] = 5;
      fl = 1; cycle(); fl = 0;
      c0 = counter;
      want[0] = {c0, 64'd5}; want[1] = {c0 + 64'd2, 64'd7}; want[2] = {c0 + 64'd4, 64'd5};
      for (int j = 0; j < 5; j++) begin
         ev = 1; ed = seq[j];
         cycle();
      end
      ev = 0;
      cycle(); cycle();
      tests++; if (bus1.count !== CW'(3)) begin fails++; $display("FAIL change_count1 got=%0d exp=3", bus1.count); end
      tests++; if (bus0.count !== CW'(5)) begin fails++; $display("FAIL change_count0 got=%0d exp=5", bus0.count); end
      for (int j = 0; j < 3; j++) begin
         tests++; if (bus1.rti_out !== want[j]) begin fails++; $display("FAIL change_entry%0d got=%h exp=%h", j, bus1.rti_out, want[j]); end
         rd = 1; cycle();
      end
      cycle(); cycle(); cycle();
      rd = 0;
      for (int k = 0; k < 2; k++) begin
         tests++; if (dut_vec(k) !== exp_vec(k)) begin fails++; $display("FAIL change_vec[%0d] got=%h exp=%h", k, dut_vec(k), exp_vec(k)); end
      end
   endtask

   task automatic test_overflow();
      int          pulses = 0;
      logic [63:0] ts14, d14;
      fl = 1; cycle(); fl = 0;
      for (int j = 0; j < 17; j++) begin
         ev = (j < 14);
         ed = {$urandom, $urandom};
         if (j == 13) begin ts14 = counter; d14 = ed; end
         cycle();
         if (bus0.overflow_error === 1'b1) pulses++;
         for (int k = 0; k < 2; k++) begin
            tests++; if (dut_vec(k) !== exp_vec(k)) begin fails++; $display("FAIL ovf_vec[%0d] c%0d got=%h exp=%h", k, j, dut_vec(k), exp_vec(k)); end
         end
      end
      ev = 0;
      tests++; if (bus0.count !== CW'(12) || bus0.full !== 1'b1) begin fails++; $display("FAIL ovf_level got count=%0d full=%b exp 12/1", bus0.count, bus0.full); end
      tests++; if (pulses != 2) begin fails++; $display("FAIL ovf_pulses got=%0d exp=2", pulses); end
      tests++; if (bus0.overflow_error_data !== {ts14, d14}) begin fails++; $display("FAIL ovf_data got=%h exp=%h", bus0.overflow_error_data, {ts14, d14}); end
   endtask

   task automatic test_full_read();
      logic [63:0] ts;
      ev = 1; ed = {$urandom, $urandom}; ts = counter;
      cycle();
      ev = 0; rd = 1;
      cycle();
      rd = 0;
      tests++; if (bus0.count !== CW'(11)) begin fails++; $display("FAIL fullrd_count got=%0d exp=11", bus0.count); end
      tests++; if (bus0.overflow_error !== 1'b1 || bus0.overflow_error_data !== {ts, ed}) begin
         fails++; $display("FAIL fullrd_ovf got=%b/%h exp=1/%h", bus0.overflow_error, bus0.overflow_error_data, {ts, ed}); end
      cycle();
      tests++; if (bus0.overflow_error !== 1'b0) begin fails++; $display("FAIL fullrd_pulse_len got=%b exp=0", bus0.overflow_error); end
   endtask

   task automatic test_underflow_flush();
      logic [127:0] prev;
      fl = 1; cycle(); fl = 0; cycle();
      prev = bus0.rti_out;
      rd = 1; cycle(); rd = 0;
      tests++; if (bus0.underflow_error !== 1'b1) begin fails++; $display("FAIL unf_pulse got=%b exp=1", bus0.underflow_error); end
      tests++; if (bus0.count !== CW'(0) || bus0.rti_out !== prev) begin fails++; $display("FAIL unf_state got count=%0d out=%h exp 0/%h", bus0.count, bus0.rti_out, prev); end
      cycle();
      tests++; if (bus0.underflow_error !== 1'b0) begin fails++; $display("FAIL unf_pulse_len got=%b exp=0", bus0.underflow_error); end
      for (int j = 0; j < 5; j++) begin ev = 1; ed = 64'(j + 100); cycle(); end
      ev = 0; cycle(); cycle();
      tests++; if (bus0.count !== CW'(5)) begin fails++; $display("FAIL flush_pre got=%0d exp=5", bus0.count); end
      fl = 1; cycle(); fl = 0;
      tests++; if (bus0.empty !== 1'b1 || bus0.count !== CW'(0)) begin fails++; $display("FAIL flush_empty got empty=%b count=%0d exp 1/0", bus0.empty, bus0.count); end
      cycle();
      for (int k = 0; k < 2; k++) begin
         tests++; if (dut_vec(k) !== exp_vec(k)) begin fails++; $display("FAIL flush_vec[%0d] got=%h exp=%h", k, dut_vec(k), exp_vec(k)); end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         ev = ($urandom_range(0, 3) != 0);
         ed = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom};
         rd = (c < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         fl = ($urandom_range(0, 63) == 0);
         as = ($urandom_range(0, 15) != 0);
         cycle();
         for (int k = 0; k < 2; k++) begin
            tests++; if (dut_vec(k) !== exp_vec(k)) begin fails++; $display("FAIL rand_vec[%0d] c%0d got=%h exp=%h", k, c, dut_vec(k), exp_vec(k)); end
         end
      end
      fl = 0; as = 1; rd = 0; ev = 0;
   endtask

   task automatic test_async_reset();
      logic [63:0] tsx, dx;
      for (int j = 0; j < 5; j++) begin ev = 1; ed = {$urandom, $urandom}; cycle(); end
      #2;
      reset = 0;
      #1;
      model_reset();
      for (int k = 0; k < 2; k++) begin
         tests++; if (dut_vec(k) !== exp_vec(k)) begin fails++; $display("FAIL async_zero[%0d] got=%h exp=%h", k, dut_vec(k), exp_vec(k)); end
      end
      cycle();
      tests++; if (bus0.count !== CW'(0) || bus0.rti_out !== 128'd0) begin fails++; $display("FAIL async_hold got count=%0d out=%h exp 0/0", bus0.count, bus0.rti_out); end
      #3;
      reset = 1;
      ed = {$urandom, $urandom}; tsx = counter; dx = ed;
      cycle();
      ev = 0;
      cycle();
      tests++; if (bus0.rti_out !== {tsx, dx} || bus0.empty !== 1'b0) begin
         fails++; $display("FAIL async_first got=%h empty=%b exp=%h/0", bus0.rti_out, bus0.empty, {tsx, dx}); end
      for (int k = 0; k < 2; k++) begin
         tests++; if (dut_vec(k) !== exp_vec(k)) begin fails++; $display("FAIL async_vec[%0d] got=%h exp=%h", k, dut_vec(k), exp_vec(k)); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_change_only();
      test_overflow();
      test_full_read();
      test_underflow_flush();
      test_random();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
